// File: rtl/axi4_write_arbiter.sv
// Two-master AXI4 write-channel arbiter: one owner per AW/W/B transaction, round-robin on contention.
// Optional beat-count checker enabled by defining AXI4_ARB_BEAT_CHECK_EN.
module axi4_write_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [ADDR_WIDTH-1:0]     s0_AWADDR,
  input  logic [7:0]                s0_AWLEN,
  input  logic [2:0]                s0_AWSIZE,
  input  logic [1:0]                s0_AWBURST,
  input  logic                      s0_AWVALID,
  output logic                      s0_AWREADY,
  input  logic [DATA_WIDTH-1:0]     s0_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   s0_WSTRB,
  input  logic                      s0_WLAST,
  input  logic                      s0_WVALID,
  output logic                      s0_WREADY,
  output logic [1:0]                s0_BRESP,
  output logic                      s0_BVALID,
  input  logic                      s0_BREADY,
  input  logic [ADDR_WIDTH-1:0]     s1_AWADDR,
  input  logic [7:0]                s1_AWLEN,
  input  logic [2:0]                s1_AWSIZE,
  input  logic [1:0]                s1_AWBURST,
  input  logic                      s1_AWVALID,
  output logic                      s1_AWREADY,
  input  logic [DATA_WIDTH-1:0]     s1_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   s1_WSTRB,
  input  logic                      s1_WLAST,
  input  logic                      s1_WVALID,
  output logic                      s1_WREADY,
  output logic [1:0]                s1_BRESP,
  output logic                      s1_BVALID,
  input  logic                      s1_BREADY,
  output logic [ADDR_WIDTH-1:0]     m_AWADDR,
  output logic [7:0]                m_AWLEN,
  output logic [2:0]                m_AWSIZE,
  output logic [1:0]                m_AWBURST,
  output logic                      m_AWVALID,
  input  logic                      m_AWREADY,
  output logic [DATA_WIDTH-1:0]     m_WDATA,
  output logic [DATA_WIDTH/8-1:0]   m_WSTRB,
  output logic                      m_WLAST,
  output logic                      m_WVALID,
  input  logic                      m_WREADY,
  input  logic [1:0]                m_BRESP,
  input  logic                      m_BVALID,
  output logic                      m_BREADY,
  output logic [1:0]                grant,
  output logic                      arb_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0] state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       ptr_q, ptr_d;
  logic       sel, in_addr, in_data, in_resp;
  logic       aw_hs, w_hs, b_hs;

  // Payloads follow the registered owner; only valids/readies are qualified by state.
  assign sel     = grant_q[1];
  assign in_addr = (state_q == S_ADDR);
  assign in_data = (state_q == S_DATA);
  assign in_resp = (state_q == S_RESP);

  assign m_AWADDR  = sel ? s1_AWADDR  : s0_AWADDR;
  assign m_AWLEN   = sel ? s1_AWLEN   : s0_AWLEN;
  assign m_AWSIZE  = sel ? s1_AWSIZE  : s0_AWSIZE;
  assign m_AWBURST = sel ? s1_AWBURST : s0_AWBURST;
  assign m_AWVALID = in_addr & (sel ? s1_AWVALID : s0_AWVALID);
  assign m_WDATA   = sel ? s1_WDATA   : s0_WDATA;
  assign m_WSTRB   = sel ? s1_WSTRB   : s0_WSTRB;
  assign m_WLAST   = sel ? s1_WLAST   : s0_WLAST;
  assign m_WVALID  = in_data & (sel ? s1_WVALID : s0_WVALID);
  assign m_BREADY  = in_resp & (sel ? s1_BREADY : s0_BREADY);

  assign s0_AWREADY = in_addr & grant_q[0] & m_AWREADY;
  assign s1_AWREADY = in_addr & grant_q[1] & m_AWREADY;
  assign s0_WREADY  = in_data & grant_q[0] & m_WREADY;
  assign s1_WREADY  = in_data & grant_q[1] & m_WREADY;
  assign s0_BVALID  = in_resp & grant_q[0] & m_BVALID;
  assign s1_BVALID  = in_resp & grant_q[1] & m_BVALID;
  assign s0_BRESP   = (in_resp & grant_q[0]) ? m_BRESP : 2'b00;
  assign s1_BRESP   = (in_resp & grant_q[1]) ? m_BRESP : 2'b00;

  assign aw_hs = m_AWVALID & m_AWREADY;
  assign w_hs  = m_WVALID & m_WREADY;
  assign b_hs  = m_BVALID & m_BREADY;
  assign grant = grant_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (s0_AWVALID | s1_AWVALID) begin
          // Pointer names the preferred master when both are requesting.
          if (s0_AWVALID & s1_AWVALID) grant_d = ptr_q ? 2'b10 : 2'b01;
          else                         grant_d = s1_AWVALID ? 2'b10 : 2'b01;
          state_d = S_ADDR;
        end
      end
      S_ADDR: if (aw_hs) state_d = S_DATA;
      S_DATA: if (w_hs & m_WLAST) state_d = S_RESP;
      S_RESP: begin
        if (b_hs) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
          ptr_d   = ~sel;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef AXI4_ARB_BEAT_CHECK_EN
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       arb_err_q, arb_err_d;

  // Counter holds the number of beats still expected after the current one.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    arb_err_d  = arb_err_q;
    if (aw_hs) begin
      beat_cnt_d = m_AWLEN;
    end else if (w_hs) begin
      beat_cnt_d = beat_cnt_q - 8'd1;
      if (m_WLAST != (beat_cnt_q == 8'd0)) arb_err_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      beat_cnt_q <= 8'd0;
      arb_err_q  <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      arb_err_q  <= arb_err_d;
    end
  end

  assign arb_err = arb_err_q;
`else
  assign arb_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_write_arbiter.sv
// Scoreboard bench for axi4_write_arbiter: randomized masters and memory, round-robin reference model.
module tb_axi4_write_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 3000;
`ifdef AXI4_ARB_BEAT_CHECK_EN
  localparam bit BEAT_CHK = 1'b1;
`else
  localparam bit BEAT_CHK = 1'b0;
`endif

  typedef struct { logic [AW-1:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; } aw_t;
  typedef struct { logic [DW-1:0] data; logic [SW-1:0] strb; logic last; } w_t;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  int   cyc = 0;
  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  logic [AW-1:0] awaddr [2];
  logic [7:0]    awlen  [2];
  logic [2:0]    awsize [2];
  logic [1:0]    awburst[2];
  logic [DW-1:0] wdata  [2];
  logic [SW-1:0] wstrb  [2];
  logic [1:0] awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0] bresp;

  logic [AW-1:0] m_awaddr;
  logic [7:0]    m_awlen;
  logic [2:0]    m_awsize;
  logic [1:0]    m_awburst;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic m_awvalid, m_wlast, m_wvalid, m_bready;
  logic mem_awready, mem_wready, mem_bvalid;
  logic [1:0] mem_bresp;
  logic [1:0] grant;
  logic arb_err;

  axi4_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s0_AWADDR(awaddr[0]), .s0_AWLEN(awlen[0]), .s0_AWSIZE(awsize[0]), .s0_AWBURST(awburst[0]),
    .s0_AWVALID(awvalid[0]), .s0_AWREADY(awready[0]),
    .s0_WDATA(wdata[0]), .s0_WSTRB(wstrb[0]), .s0_WLAST(wlast[0]),
    .s0_WVALID(wvalid[0]), .s0_WREADY(wready[0]),
    .s0_BRESP(bresp[1:0]), .s0_BVALID(bvalid[0]), .s0_BREADY(bready[0]),
    .s1_AWADDR(awaddr[1]), .s1_AWLEN(awlen[1]), .s1_AWSIZE(awsize[1]), .s1_AWBURST(awburst[1]),
    .s1_AWVALID(awvalid[1]), .s1_AWREADY(awready[1]),
    .s1_WDATA(wdata[1]), .s1_WSTRB(wstrb[1]), .s1_WLAST(wlast[1]),
    .s1_WVALID(wvalid[1]), .s1_WREADY(wready[1]),
    .s1_BRESP(bresp[3:2]), .s1_BVALID(bvalid[1]), .s1_BREADY(bready[1]),
    .m_AWADDR(m_awaddr), .m_AWLEN(m_awlen), .m_AWSIZE(m_awsize), .m_AWBURST(m_awburst),
    .m_AWVALID(m_awvalid), .m_AWREADY(mem_awready),
    .m_WDATA(m_wdata), .m_WSTRB(m_wstrb), .m_WLAST(m_wlast),
    .m_WVALID(m_wvalid), .m_WREADY(mem_wready),
    .m_BRESP(mem_bresp), .m_BVALID(mem_bvalid), .m_BREADY(m_bready),
    .grant(grant), .arb_err(arb_err)
  );

  int checks = 0;
  int failures = 0;
  int mem_mode = 0;   // 0 zero-wait, 1 random stalls, 2 WREADY toggling
  bit mdelay = 1'b0;  // masters insert random gaps

  aw_t awq0[$], awq1[$];
  w_t  wq0[$],  wq1[$];
  int  order_q[$];
  bit  in_burst = 1'b0;
  int  cur = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  task automatic drop_master(input int m);
    awvalid[m] = 1'b0; wvalid[m] = 1'b0; wlast[m] = 1'b0; bready[m] = 1'b0;
  endtask

  // One full write from master m; returns cycles from AWVALID to B handshake, 0 if aborted.
  task automatic do_write(input int m, input logic [AW-1:0] addr, input logic [7:0] len,
                          input int nbeats, input logic [DW-1:0] d0, output int lat);
    aw_t a;
    w_t  beats[$];
    w_t  w;
    int  t0, n;
    bit  ok;
    lat = 0;
    a.addr = addr; a.len = len; a.size = 3'($urandom_range(0, 2)); a.burst = 2'b01;
    for (int b = 0; b < nbeats; b++) begin
      w.data = (b == 0) ? d0 : $urandom;
      w.strb = SW'($urandom);
      w.last = (b == nbeats - 1);
      beats.push_back(w);
      if (m == 0) wq0.push_back(w); else wq1.push_back(w);
    end
    if (m == 0) awq0.push_back(a); else awq1.push_back(a);
    awaddr[m] = a.addr; awlen[m] = a.len; awsize[m] = a.size; awburst[m] = a.burst;
    wdata[m] = beats[0].data; wstrb[m] = beats[0].strb; wlast[m] = beats[0].last;
    wvalid[m] = 1'($urandom_range(0, 1));
    awvalid[m] = 1'b1;
    t0 = cyc;
    ok = 1'b0;
    for (n = 0; n < TMO; n++) begin
      @(negedge ACLK);
      if (!ARESETn) begin drop_master(m); return; end
      if (awready[m]) begin ok = 1'b1; break; end
    end
    @(posedge ACLK); #1;
    awvalid[m] = 1'b0;
    if (!ok) begin fail($sformatf("aw_timeout m%0d", m)); drop_master(m); return; end
    for (int b = 0; b < nbeats; b++) begin
      if (mdelay && !wvalid[m]) repeat ($urandom_range(0, 2)) begin @(posedge ACLK); #1; end
      wdata[m] = beats[b].data; wstrb[m] = beats[b].strb; wlast[m] = beats[b].last;
      wvalid[m] = 1'b1;
      ok = 1'b0;
      for (n = 0; n < TMO; n++) begin
        @(negedge ACLK);
        if (!ARESETn) begin drop_master(m); return; end
        if (wready[m]) begin ok = 1'b1; break; end
      end
      @(posedge ACLK); #1;
      wvalid[m] = 1'b0;
      if (!ok) begin fail($sformatf("w_timeout m%0d", m)); drop_master(m); return; end
    end
    wlast[m] = 1'b0;
    if (mdelay) repeat ($urandom_range(0, 2)) begin @(posedge ACLK); #1; end
    bready[m] = 1'b1;
    ok = 1'b0;
    for (n = 0; n < TMO; n++) begin
      @(negedge ACLK);
      if (!ARESETn) begin drop_master(m); return; end
      if (bvalid[m]) begin ok = 1'b1; break; end
    end
    lat = cyc - t0 + 1;
    @(posedge ACLK); #1;
    bready[m] = 1'b0;
    if (!ok) fail($sformatf("b_timeout m%0d", m));
  endtask

  // Memory slave: AW/W acceptance per mem_mode, one B response per completed burst.
  initial begin
    bit wl_hs, b_hs, pend_b;
    int bdly;
    pend_b = 1'b0; bdly = 0;
    mem_awready = 1'b0; mem_wready = 1'b0; mem_bvalid = 1'b0; mem_bresp = 2'b00;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        pend_b = 1'b0; mem_bvalid = 1'b0; mem_awready = 1'b0; mem_wready = 1'b0;
        continue;
      end
      wl_hs = m_wvalid & mem_wready & m_wlast;
      b_hs  = mem_bvalid & m_bready;
      @(posedge ACLK); #1;
      if (b_hs) mem_bvalid = 1'b0;
      if (wl_hs) begin pend_b = 1'b1; bdly = (mem_mode == 1) ? $urandom_range(0, 3) : 0; end
      if (pend_b && !mem_bvalid) begin
        if (bdly == 0) begin
          mem_bvalid = 1'b1;
          mem_bresp  = (mem_mode == 1) ? 2'($urandom) : 2'b00;
          pend_b = 1'b0;
        end else bdly--;
      end
      case (mem_mode)
        0: begin mem_awready = 1'b1; mem_wready = 1'b1; end
        1: begin mem_awready = 1'($urandom); mem_wready = 1'($urandom); end
        default: begin mem_awready = 1'b1; mem_wready = ~mem_wready; end
      endcase
    end
  end

  // Monitor: round-robin reference, channel isolation, payload scoreboard.
  initial begin
    bit ptr, arb_pend, win;
    int clear_at, o, nx;
    logic [1:0] exp_grant;
    aw_t a;
    w_t  w;
    ptr = 1'b0; arb_pend = 1'b0; clear_at = -1; exp_grant = 2'b00;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        ptr = 1'b0; arb_pend = 1'b0; clear_at = -1; in_burst = 1'b0;
        awq0.delete(); awq1.delete(); wq0.delete(); wq1.delete();
        continue;
      end
      if (arb_pend) begin chk("grant", grant, exp_grant); arb_pend = 1'b0; end
      if (clear_at == cyc) begin chk("grant_clear", grant, 2'b00); clear_at = -1; end
      if (grant == 2'b00) begin
        chk("idle_outputs", {m_awvalid, m_wvalid, m_bready, awready, wready, bvalid}, 0);
        if (awvalid != 2'b00) begin
          win = (awvalid == 2'b11) ? ptr : awvalid[1];
          exp_grant = win ? 2'b10 : 2'b01;
          arb_pend = 1'b1;
        end
      end else begin
        o = grant[1] ? 1 : 0;
        nx = 1 - o;
        if (awvalid[nx] | wvalid[nx] | bready[nx])
          chk("blocked", {awready[nx], wready[nx], bvalid[nx], bresp[2*nx +: 2]}, 0);
        if (m_awvalid & mem_awready) begin
          if ((o == 0 && awq0.size() == 0) || (o == 1 && awq1.size() == 0)) fail("aw_unexpected");
          else begin
            a = (o == 0) ? awq0.pop_front() : awq1.pop_front();
            chk("aw_payload", {m_awaddr, m_awlen, m_awsize, m_awburst}, {a.addr, a.len, a.size, a.burst});
            in_burst = 1'b1; cur = o;
            order_q.push_back(o);
          end
        end
        if (m_wvalid & mem_wready) begin
          if (!in_burst || (cur == 0 && wq0.size() == 0) || (cur == 1 && wq1.size() == 0))
            fail("w_outside_burst");
          else begin
            w = (cur == 0) ? wq0.pop_front() : wq1.pop_front();
            chk("w_beat", {m_wdata, m_wstrb, m_wlast}, {w.data, w.strb, w.last});
            if (w.last) in_burst = 1'b0;
          end
        end
        if (bvalid[o] & bready[o]) begin
          chk("bresp", bresp[2*o +: 2], mem_bresp);
          ptr = (nx == 1);
          clear_at = cyc + 1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic pulse_reset();
    @(posedge ACLK); #1;
    ARESETn = 1'b0;
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1'b1;
  endtask

  task automatic chk_order(input int n, input int e0, input int e1, input int e2, input int e3);
    int exp_o[4];
    exp_o[0] = e0; exp_o[1] = e1; exp_o[2] = e2; exp_o[3] = e3;
    chk("order_len", order_q.size(), n);
    for (int i = 0; i < n && i < order_q.size(); i++)
      chk($sformatf("order%0d", i), order_q[i], exp_o[i]);
  endtask

  int l0, l1, lat;
  bit hit;

  initial begin
    for (int m = 0; m < 2; m++) begin
      awaddr[m] = '0; awlen[m] = '0; awsize[m] = '0; awburst[m] = '0;
      wdata[m] = '0; wstrb[m] = '0;
    end
    awvalid = '0; wvalid = '0; wlast = '0; bready = '0;
    ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("reset_grant", grant, 2'b00);
    chk("reset_arb_err", arb_err, 1'b0);
    chk("reset_outputs", {m_awvalid, m_wvalid, m_bready, awready, wready, bvalid}, 0);
    @(posedge ACLK); #1 ARESETn = 1'b1;

    // Single zero-wait write from master 0
    mem_mode = 0; mdelay = 1'b0;
    repeat (2) @(posedge ACLK); #1;
    do_write(0, 16'h0010, 8'd0, 1, 32'hDEADBEEF, lat);
    chk("single_latency", lat, 4);

    // Simultaneous requests straight out of reset
    pulse_reset();
    order_q.delete();
    fork
      do_write(0, 16'h0100, 8'd1, 2, $urandom, l0);
      do_write(1, 16'h0200, 8'd0, 1, $urandom, l1);
    join
    chk_order(2, 0, 1, 0, 0);

    // Continuous contention
    mem_mode = 1;
    order_q.delete();
    fork
      for (int i = 0; i < 2; i++) do_write(0, AW'($urandom), 8'(i), i + 1, $urandom, l0);
      for (int i = 0; i < 2; i++) do_write(1, AW'($urandom), 8'(i + 1), i + 2, $urandom, l1);
    join
    chk_order(4, 0, 1, 0, 1);

    // Burst under WREADY toggling while master 0 waits
    mem_mode = 2;
    order_q.delete();
    fork
      do_write(1, 16'h3000, 8'd3, 4, $urandom, l1);
      begin repeat (2) @(posedge ACLK); #1; do_write(0, 16'h4000, 8'd0, 1, $urandom, l0); end
    join
    chk_order(2, 1, 0, 0, 0);

    // Reset while master 1 is mid-burst
    mem_mode = 1;
    fork
      do_write(1, 16'h5000, 8'd7, 8, $urandom, l1);
      begin
        hit = 1'b0;
        for (int n = 0; n < TMO; n++) begin
          @(negedge ACLK);
          if (in_burst && wq1.size() <= 5) begin hit = 1'b1; break; end
        end
        if (!hit) fail("midburst_not_reached");
        @(posedge ACLK); #1 ARESETn = 1'b0;
        @(negedge ACLK);
        chk("rst_grant", grant, 2'b00);
        chk("rst_outputs", {m_awvalid, m_wvalid, m_bready, awready, wready, bvalid}, 0);
        @(posedge ACLK); #1 ARESETn = 1'b1;
      end
    join
    order_q.delete();
    fork
      do_write(1, 16'h6000, 8'd2, 3, $urandom, l1);
      do_write(0, 16'h6100, 8'd0, 1, $urandom, l0);
    join
    chk_order(2, 0, 1, 0, 0);

    // Randomized traffic from both masters
    mdelay = 1'b1;
    fork
      for (int i = 0; i < 12; i++) begin
        automatic int ln = (i == 5) ? 255 : $urandom_range(0, 15);
        do_write(0, AW'($urandom), 8'(ln), ln + 1, $urandom, l0);
      end
      for (int i = 0; i < 12; i++) begin
        automatic int ln = $urandom_range(0, 15);
        do_write(1, AW'($urandom), 8'(ln), ln + 1, $urandom, l1);
      end
    join
    @(negedge ACLK);
    chk("arb_err_clean", arb_err, 1'b0);

    // Early WLAST: AWLEN 3 but WLAST on beat 2
    @(posedge ACLK); #1;
    do_write(0, 16'h7000, 8'd3, 2, $urandom, l0);
    @(negedge ACLK);
    chk("arb_err_set", arb_err, BEAT_CHK);
    @(posedge ACLK); #1;
    do_write(1, 16'h7100, 8'd1, 2, $urandom, l1);
    @(negedge ACLK);
    chk("arb_err_held", arb_err, BEAT_CHK);
    pulse_reset();
    @(negedge ACLK);
    chk("arb_err_cleared", arb_err, 1'b0);

    repeat (3) @(posedge ACLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_write_arbiter.md
# axi4_write_arbiter

Two-requester AXI4 write-channel arbiter that shares the single `axi4_memory` write port between two AXI4 masters (master 0, master 1). It grants one master at a time for a complete write transaction (AW, then all W beats, then B) and returns ownership only after the write response handshake. Round-robin priority gives fairness when both masters request together. It sits between the masters' `arb_if` write channels and the memory's slave write channels; read channels bypass it.

## Interface
- ADDR_WIDTH, 16, AWADDR width on all ports
- DATA_WIDTH, 32, WDATA width; WSTRB is DATA_WIDTH/8

- ACLK  in  1  clock; all state updates on rising edge
- ARESETn  in  1  asynchronous, active-low reset
- sN_AWADDR / sN_AWLEN / sN_AWSIZE / sN_AWBURST  in  ADDR_WIDTH/8/3/2  address-write payload from master N (N = 0, 1)
- sN_AWVALID  in  1 / sN_AWREADY  out  1  AW handshake, master N
- sN_WDATA / sN_WSTRB / sN_WLAST  in  DATA_WIDTH/DATA_WIDTH/8/1  write-data payload, master N
- sN_WVALID  in  1 / sN_WREADY  out  1  W handshake, master N
- sN_BRESP  out  2 / sN_BVALID  out  1 / sN_BREADY  in  1  response channel, master N
- m_AWADDR, m_AWLEN, m_AWSIZE, m_AWBURST, m_AWVALID  out  as above  AW to memory
- m_AWREADY  in  1  memory AW ready
- m_WDATA, m_WSTRB, m_WLAST, m_WVALID  out  as above  W to memory
- m_WREADY  in  1  memory W ready
- m_BRESP  in  2 / m_BVALID  in  1 / m_BREADY  out  1  B from memory
- grant  out  2  one-hot owner (01 = master 0, 10 = master 1, 00 = none)
- arb_err  out  1  sticky beat-count protocol error (see Configuration)

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: if any sN_AWVALID = 1, register the winner into `grant` and go to ADDR. If both request, the master selected by the round-robin pointer wins; otherwise the sole requester wins.
- ADDR: route the granted master's AW payload and AWVALID to m_; return m_AWREADY to it. On m_AWVALID & m_AWREADY, go to DATA.
- DATA: route the granted master's W channel to m_; return m_WREADY. On a W handshake with WLAST = 1, go to RESP.
- RESP: route m_BRESP/m_BVALID to the granted master and its BREADY to m_BREADY. On the B handshake, go to IDLE, clear `grant`, and set the pointer to the other master.
- The non-granted master sees AWREADY = WREADY = BVALID = 0 and BRESP = 0. Its requests stay pending, with no side effects.
- Channel muxing is combinational from the registered `grant` and state. Outside its active state, each m_ valid and each master-side ready is forced to 0.
- The pointer changes only on B completion, never on grant.
- An ARESETn assertion at any point returns to IDLE immediately. An in-flight burst is abandoned, with no response generated.

## Timing
- Reset values: state IDLE, grant 00, pointer = master 0, arb_err 0. All m_ valids, sN_AWREADY/WREADY/BVALID, and m_BREADY are 0.
- Arbitration latency: AWVALID sampled in IDLE gives a grant and m_AWVALID in the next cycle.
- A zero-wait-state single-beat write takes 4 cycles from AWVALID to B handshake: IDLE, ADDR, DATA, RESP.
- Back-to-back: one IDLE cycle between transactions. The other master is granted in the cycle after the B handshake if it is requesting.
- W beats presented before the AW handshake are not accepted (WREADY = 0 until DATA).
- AWLEN is passed through unchanged. Burst length is 1–256 beats.

## Configuration
- `AXI4_ARB_BEAT_CHECK_EN` defined:
  - An 8-bit beat counter loads AWLEN at the AW handshake and decrements on each W handshake.
  - arb_err sets, and stays set until reset, if WLAST = 1 while count ≠ 0, or if WLAST = 0 while count = 0.
  - FSM sequencing still follows WLAST.
- Not defined: no counter is built and arb_err is tied to 0.

## Test plan
- Reset, then single request: s0 writes AWADDR 0x0010, AWLEN 0, WDATA 0xDEADBEEF. Expect grant 01 one cycle after AWVALID, memory receives 0xDEADBEEF at 0x0010, s0 gets BRESP 00, grant returns to 00.
- Simultaneous request from reset: both AWVALID in the same cycle. Expect master 0 served first, then master 1 granted in the cycle after master 0's B handshake.
- Fairness: both masters request continuously for 4 transactions. Expect grant order 0, 1, 0, 1.
- Burst with memory stalls: s1 sends AWLEN 3 with m_WREADY toggling. Expect 4 beats forwarded in order, m_WLAST only on beat 4, and s0 blocked (AWREADY 0) throughout.
- Reset mid-burst: ARESETn low during DATA. Expect grant 00, all valids/readies 0, pointer at master 0; a new s1 request after release completes normally.
- With `AXI4_ARB_BEAT_CHECK_EN`: AWLEN 3 with WLAST on beat 2. Expect arb_err = 1 after that beat, held until reset. Without the macro, arb_err stays 0.
